// File: rtl/pipeline_if_pkg.sv
// Shared types and default widths for the instruction-fetch stage.
package pipeline_if_pkg;

  // IF_REQ: free to issue; IF_WAIT: one request outstanding;
  // IF_DROP: outstanding request killed by a redirect, its response is discarded.
  typedef enum logic [1:0] {
    IF_REQ  = 2'd0,
    IF_WAIT = 2'd1,
    IF_DROP = 2'd2
  } if_state_e;

  localparam int XLEN_DEF = 32;
  localparam int ILEN_DEF = 32;

endpackage

// File: rtl/pipeline_if_stage_reg_ce.sv
// Clock-enabled register with asynchronous active-high reset to a fixed value.
module reg_ce
  import pipeline_if_pkg::*;
#(
  parameter int           W       = XLEN_DEF,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_ce,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Load i_d when enabled; reset forces RST_VAL immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= RST_VAL;
    end else if (i_ce) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipeline_if_stage.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time and
// holds the returned instruction in a one-entry IF/ID slot. A redirect from EX
// reloads the PC, empties the slot and kills any fetch still in flight.
module pipeline_if_stage
  import pipeline_if_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter int              ILEN     = ILEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [ILEN-1:0] id_instr,
  input  logic            id_ready,
  output logic [XLEN-1:0] pc_out
);

  if_state_e       r_state;
  logic            r_id_valid;
  logic [XLEN-1:0] w_pc;
  logic [XLEN-1:0] w_fetch_pc;
  logic [XLEN-1:0] w_pc_next;
  logic            w_slot_free;
  logic            w_req_valid;
  logic            w_issue;
  logic            w_fill;
  logic            w_pc_ce;

  // A request is only issued when the slot will be empty to receive it, so a
  // fill never collides with a still-occupied slot.
  assign w_slot_free = !r_id_valid || id_ready;
  assign w_req_valid = (r_state == IF_REQ) && !stall && w_slot_free && !redirect_valid;
  assign w_issue     = w_req_valid && imem_req_ready;
  assign w_fill      = (r_state == IF_WAIT) && imem_resp_valid && !redirect_valid;
  assign w_pc_ce     = redirect_valid || w_issue;
  assign w_pc_next   = redirect_valid ? redirect_pc : (w_pc + XLEN'(PC_STEP));

  reg_ce #(.W(XLEN), .RST_VAL(RESET_PC)) u_pc (
    .clk(clk), .rst(rst), .i_ce(w_pc_ce), .i_d(w_pc_next), .o_q(w_pc)
  );

  reg_ce #(.W(XLEN), .RST_VAL('0)) u_fetch_pc (
    .clk(clk), .rst(rst), .i_ce(w_issue), .i_d(w_pc), .o_q(w_fetch_pc)
  );

  reg_ce #(.W(XLEN), .RST_VAL('0)) u_id_pc (
    .clk(clk), .rst(rst), .i_ce(w_fill), .i_d(w_fetch_pc), .o_q(id_pc)
  );

  reg_ce #(.W(ILEN), .RST_VAL('0)) u_id_instr (
    .clk(clk), .rst(rst), .i_ce(w_fill), .i_d(imem_resp_data), .o_q(id_instr)
  );

  // Fetch FSM and slot-valid flag; redirect has priority over fill and consume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IF_REQ;
      r_id_valid <= 1'b0;
    end else begin
      if (redirect_valid) begin
        r_id_valid <= 1'b0;
      end else if (w_fill) begin
        r_id_valid <= 1'b1;
      end else if (id_ready) begin
        r_id_valid <= 1'b0;
      end

      case (r_state)
        IF_REQ: begin
          if (w_issue) r_state <= IF_WAIT;
        end
        IF_WAIT: begin
          if (imem_resp_valid)     r_state <= IF_REQ;
          else if (redirect_valid) r_state <= IF_DROP;
        end
        IF_DROP: begin
          if (imem_resp_valid) r_state <= IF_REQ;
        end
        default: r_state <= IF_REQ;
      endcase
    end
  end

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = w_pc;
  assign id_valid       = r_id_valid;
  assign pc_out         = w_pc;

endmodule

// File: tb/tb_pipeline_if_stage.sv
// Bench for pipeline_if_stage: directed scenarios followed by random traffic,
// all checked cycle by cycle against a transaction-level fetch model.
module tb_pipeline_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_ready = 1'b1;
  logic [31:0] pc_out;

  pipeline_if_stage dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
    .id_ready(id_ready), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: next PC, whether a fetch is in flight, whether it was killed,
  // and the content of the decode slot.
  logic [31:0] m_pc, m_fetch, m_idpc, m_idinstr;
  bit          m_busy, m_kill, m_idv;

  // Memory: a single pending request answered after a countdown.
  bit          mem_pend;
  logic [31:0] mem_addr;
  int          mem_cnt;
  int          mem_lat = 1;
  bit          mem_rand = 1'b0;

  logic [31:0] issued[$];
  logic [31:0] pc_hold;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_fetch = '0; m_idpc = '0; m_idinstr = '0;
    m_busy = 0; m_kill = 0; m_idv = 0;
    mem_pend = 0; mem_cnt = 0; mem_addr = '0;
  endtask

  // One clock cycle: memory drives at negedge, combinational outputs checked,
  // model advanced at posedge, registered outputs checked just after.
  task automatic cycle();
    bit exp_req, acc, resp, fill;
    @(negedge clk);
    if (mem_pend && mem_cnt == 0) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mdata(mem_addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
      if (mem_pend) mem_cnt--;
    end
    #1;
    exp_req = !m_busy && !stall && (!m_idv || id_ready) && !redirect_valid;
    chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req});
    chk("req_addr", imem_req_addr, m_pc);
    if (imem_req_valid && imem_req_ready) issued.push_back(imem_req_addr);
    @(posedge clk);
    acc  = exp_req && imem_req_ready;
    resp = imem_resp_valid && m_busy;
    fill = !redirect_valid && resp && !m_kill;
    if (imem_resp_valid) mem_pend = 0;
    if (acc) begin
      mem_pend = 1;
      mem_addr = m_pc;
      mem_cnt  = (mem_rand ? int'($urandom_range(3, 1)) : mem_lat) - 1;
    end
    if (redirect_valid) m_idv = 0;
    else if (fill) begin
      m_idv = 1; m_idpc = m_fetch; m_idinstr = imem_resp_data;
    end else if (id_ready) m_idv = 0;
    if (resp) begin
      m_busy = 0; m_kill = 0;
    end else if (redirect_valid && m_busy) m_kill = 1;
    if (redirect_valid) m_pc = redirect_pc;
    else if (acc) begin
      m_fetch = m_pc; m_pc = m_pc + 32'd4; m_busy = 1; m_kill = 0;
    end
    #1;
    chk("id_valid", {31'b0, id_valid}, {31'b0, m_idv});
    if (m_idv) begin
      chk("id_pc", id_pc, m_idpc);
      chk("id_instr", id_instr, m_idinstr);
    end
    chk("pc_out", pc_out, m_pc);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    rst = 1'b1; redirect_valid = 0; stall = 0; imem_resp_valid = 0;
    #1;
    chk("rst_id_valid", {31'b0, id_valid}, 32'h0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_instr", id_instr, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic bit cond(input int mode);
    case (mode)
      0:       return mem_pend && mem_cnt > 0;
      1:       return mem_pend && mem_cnt == 0;
      default: return !m_busy;
    endcase
  endfunction

  task automatic wait_until(input int mode, input string tag);
    for (int i = 0; i < 20; i++) begin
      if (cond(mode)) break;
      cycle();
    end
    chk(tag, {31'b0, cond(mode)}, 32'h1);
  endtask

  initial begin
    do_reset();

    // Zero-wait memory: 0,4,8 on alternate cycles.
    issued.delete();
    repeat (6) cycle();
    chk("seq_count", issued.size(), 3);
    chk("seq_addr0", issued[0], 32'h0);
    chk("seq_addr1", issued[1], 32'h4);
    chk("seq_addr2", issued[2], 32'h8);
    chk("seq_last_idpc", id_pc, 32'h8);

    // Decode not ready: slot holds PC 0, no new requests.
    do_reset();
    id_ready = 0;
    issued.delete();
    repeat (6) cycle();
    chk("hold_count", issued.size(), 1);
    chk("hold_idpc", id_pc, 32'h0);
    chk("hold_idvalid", {31'b0, id_valid}, 32'h1);
    id_ready = 1;
    issued.delete();
    repeat (2) cycle();
    chk("hold_next_addr", issued[0], 32'h4);

    // Redirect while a fetch is outstanding.
    mem_lat = 3;
    wait_until(0, "wait_outstanding");
    redirect_valid = 1; redirect_pc = 32'h100;
    issued.delete();
    cycle();
    redirect_valid = 0;
    repeat (8) cycle();
    chk("redir_addr0", issued[0], 32'h100);
    chk("redir_addr1", issued[1], 32'h104);

    // Redirect in the same cycle as the response.
    mem_lat = 2;
    wait_until(1, "wait_resp_next");
    redirect_valid = 1; redirect_pc = 32'h200;
    issued.delete();
    cycle();
    redirect_valid = 0;
    cycle();
    chk("redir_resp_addr", issued[0], 32'h200);

    // Stall while a response is still owed.
    wait_until(0, "wait_stall");
    stall = 1; id_ready = 0;
    pc_hold = pc_out;
    repeat (3) cycle();
    chk("stall_pc", pc_out, pc_hold);
    chk("stall_capture", {31'b0, id_valid}, 32'h1);
    stall = 0; id_ready = 1;

    // PC wrap at the top of the address space.
    mem_lat = 3;
    wait_until(2, "wait_idle");
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
    cycle();
    redirect_valid = 0;
    issued.delete();
    cycle();
    chk("wrap_addr", issued[0], 32'hFFFF_FFFC);
    chk("wrap_pc", pc_out, 32'h0);

    // Reset with the wrap fetch still outstanding.
    do_reset();
    mem_lat = 1;
    issued.delete();
    repeat (2) cycle();
    chk("post_rst_addr", issued[0], 32'h0);

    // Random traffic.
    mem_rand = 1;
    for (int i = 0; i < 400; i++) begin
      redirect_valid = ($urandom_range(19) == 0);
      redirect_pc    = $urandom & 32'hFFFF_FFFC;
      stall          = ($urandom_range(4) == 0);
      imem_req_ready = ($urandom_range(9) < 7);
      id_ready       = ($urandom_range(9) < 6);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
